// File: rtl/aq_djpeg_mcu_sched.sv
// aq_djpeg_mcu_sched
// Double-buffered MCU scheduler between the IDCT block writer and the colour
// converter. The writer fills one bank with BPM 8x8 blocks while the converter
// drains the other bank. Each bank carries the MCU X/Y it holds and a flag
// marking the final MCU of the frame.
module aq_djpeg_mcu_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        CfgStart,
    input  logic [11:0] CfgWidthMcu,
    input  logic [11:0] CfgHeightMcu,
    input  logic [1:0]  CfgSubW,
    input  logic [1:0]  CfgSubH,
    input  logic        BlkValid,
    output logic        BlkReady,
    output logic        WrBank,
    output logic [2:0]  WrBlk,
    output logic        ConvEnable,
    output logic        ConvBank,
    output logic [11:0] ConvBlockX,
    output logic [11:0] ConvBlockY,
    output logic [2:0]  ConvComp,
    output logic [1:0]  ConvSubW,
    output logic [1:0]  ConvSubH,
    input  logic        ConvReadNext,
    output logic        Busy,
    output logic        FrameDone,
    output logic        ErrOverflow
);

    typedef enum logic [1:0] {BK_FREE, BK_FILL, BK_FULL, BK_CONV} bank_st_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_WAIT} rd_st_t;

    // latched frame configuration
    logic [11:0] r_width;
    logic [11:0] r_height;
    logic [1:0]  r_subw;
    logic [1:0]  r_subh;
    logic [2:0]  r_bpm;
    logic [23:0] r_total;

    // write side
    logic        r_wr_bank;
    logic [2:0]  r_wr_blk;
    logic [11:0] r_wr_x;
    logic [11:0] r_wr_y;
    logic [23:0] r_wr_mcus;
    logic        r_err;

    // per-bank state and tags
    bank_st_t    r_bank_st   [2];
    logic [11:0] r_bank_x    [2];
    logic [11:0] r_bank_y    [2];
    logic        r_bank_last [2];

    // reader side
    rd_st_t      r_rd_st;
    logic        r_conv_bank;
    logic        r_conv_en;
    logic [11:0] r_conv_x;
    logic [11:0] r_conv_y;
    logic [2:0]  r_conv_comp;
    logic [1:0]  r_conv_subw;
    logic [1:0]  r_conv_subh;
    logic        r_busy;
    logic        r_frame_done;

    // combinational helpers
    logic        w_start;
    logic [1:0]  w_cfg_subw;
    logic [1:0]  w_cfg_subh;
    logic [2:0]  w_cfg_bpm;
    logic [11:0] w_cfg_w;
    logic [11:0] w_cfg_h;
    logic [23:0] w_cfg_total;
    bank_st_t    w_wr_st;
    bank_st_t    w_rd_st;
    logic        w_blk_ready;
    logic        w_wr_acc;
    logic        w_wr_done;
    logic        w_wr_last;
    logic        w_issue;
    logic        w_release;

    // A start is only honoured between frames.
    assign w_start     = CfgStart & ~r_busy;

    // Sampling factors other than 2 behave as 1; zero dimensions behave as 1.
    assign w_cfg_subw  = (CfgSubW == 2'd2) ? 2'd2 : 2'd1;
    assign w_cfg_subh  = (CfgSubH == 2'd2) ? 2'd2 : 2'd1;
    assign w_cfg_w     = (CfgWidthMcu  == 12'd0) ? 12'd1 : CfgWidthMcu;
    assign w_cfg_h     = (CfgHeightMcu == 12'd0) ? 12'd1 : CfgHeightMcu;
    assign w_cfg_total = 24'(w_cfg_w) * 24'(w_cfg_h);

    // Blocks per MCU: W*H luma blocks plus one Cb and one Cr.
    always_comb begin
        w_cfg_bpm = 3'd3;
        case ({w_cfg_subw == 2'd2, w_cfg_subh == 2'd2})
            2'b00:   w_cfg_bpm = 3'd3;
            2'b10:   w_cfg_bpm = 3'd4;
            2'b01:   w_cfg_bpm = 3'd4;
            default: w_cfg_bpm = 3'd6;
        endcase
    end

    assign w_wr_st     = r_bank_st[r_wr_bank];
    assign w_rd_st     = r_bank_st[r_conv_bank];
    assign w_blk_ready = r_busy && ((w_wr_st == BK_FREE) || (w_wr_st == BK_FILL))
                         && (r_wr_mcus < r_total);
    assign w_wr_acc    = BlkValid & w_blk_ready;
    assign w_wr_done   = w_wr_acc && (r_wr_blk == 3'(r_bpm - 3'd1));
    assign w_wr_last   = (r_wr_x == r_width - 12'd1) && (r_wr_y == r_height - 12'd1);
    assign w_issue     = r_busy && (r_rd_st == RD_IDLE) && (w_rd_st == BK_FULL);
    assign w_release   = (r_rd_st == RD_WAIT) && ConvReadNext;

    // Config latch, write block/MCU counters and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_width   <= '0;
            r_height  <= '0;
            r_subw    <= '0;
            r_subh    <= '0;
            r_bpm     <= '0;
            r_total   <= '0;
            r_wr_bank <= 1'b0;
            r_wr_blk  <= '0;
            r_wr_x    <= '0;
            r_wr_y    <= '0;
            r_wr_mcus <= '0;
            r_err     <= 1'b0;
        end else if (w_start) begin
            r_width   <= w_cfg_w;
            r_height  <= w_cfg_h;
            r_subw    <= w_cfg_subw;
            r_subh    <= w_cfg_subh;
            r_bpm     <= w_cfg_bpm;
            r_total   <= w_cfg_total;
            r_wr_bank <= 1'b0;
            r_wr_blk  <= '0;
            r_wr_x    <= '0;
            r_wr_y    <= '0;
            r_wr_mcus <= '0;
            r_err     <= 1'b0;
        end else begin
            if (BlkValid && !w_blk_ready)
                r_err <= 1'b1;
            if (w_wr_done) begin
                r_wr_blk  <= '0;
                r_wr_bank <= ~r_wr_bank;
                r_wr_mcus <= r_wr_mcus + 24'd1;
                if (r_wr_x == r_width - 12'd1) begin
                    r_wr_x <= '0;
                    r_wr_y <= r_wr_y + 12'd1;
                end else begin
                    r_wr_x <= r_wr_x + 12'd1;
                end
            end else if (w_wr_acc) begin
                r_wr_blk <= r_wr_blk + 3'd1;
            end
        end
    end

    // Bank state machines; a bank can only be touched by one side at a time,
    // so writer and reader events on different banks both land in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                r_bank_st[b]   <= BK_FREE;
                r_bank_x[b]    <= '0;
                r_bank_y[b]    <= '0;
                r_bank_last[b] <= 1'b0;
            end
        end else if (w_start) begin
            for (int b = 0; b < 2; b++) begin
                r_bank_st[b]   <= BK_FREE;
                r_bank_x[b]    <= '0;
                r_bank_y[b]    <= '0;
                r_bank_last[b] <= 1'b0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_wr_acc && (r_wr_bank == 1'(b))) begin
                    if (w_wr_done) begin
                        r_bank_st[b]   <= BK_FULL;
                        r_bank_x[b]    <= r_wr_x;
                        r_bank_y[b]    <= r_wr_y;
                        r_bank_last[b] <= w_wr_last;
                    end else begin
                        r_bank_st[b]   <= BK_FILL;
                    end
                end else if (w_issue && (r_conv_bank == 1'(b))) begin
                    r_bank_st[b] <= BK_CONV;
                end else if (w_release && (r_conv_bank == 1'(b))) begin
                    r_bank_st[b] <= BK_FREE;
                end
            end
        end
    end

    // Reader FSM: issue a full bank to the converter, wait for its release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_st      <= RD_IDLE;
            r_conv_bank  <= 1'b0;
            r_conv_en    <= 1'b0;
            r_conv_x     <= '0;
            r_conv_y     <= '0;
            r_conv_comp  <= '0;
            r_conv_subw  <= '0;
            r_conv_subh  <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (w_start) begin
            r_rd_st      <= RD_IDLE;
            r_conv_bank  <= 1'b0;
            r_conv_en    <= 1'b0;
            r_busy       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_conv_en    <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_rd_st)
                RD_IDLE: begin
                    if (w_issue) begin
                        r_rd_st     <= RD_ISSUE;
                        r_conv_en   <= 1'b1;
                        r_conv_x    <= r_bank_x[r_conv_bank];
                        r_conv_y    <= r_bank_y[r_conv_bank];
                        r_conv_comp <= r_bpm;
                        r_conv_subw <= r_subw;
                        r_conv_subh <= r_subh;
                    end
                end
                RD_ISSUE: r_rd_st <= RD_WAIT;
                RD_WAIT: begin
                    if (ConvReadNext) begin
                        r_rd_st     <= RD_IDLE;
                        r_conv_bank <= ~r_conv_bank;
                        if (r_bank_last[r_conv_bank]) begin
                            r_frame_done <= 1'b1;
                            r_busy       <= 1'b0;
                        end
                    end
                end
                default: r_rd_st <= RD_IDLE;
            endcase
        end
    end

    assign BlkReady    = w_blk_ready;
    assign WrBank      = r_wr_bank;
    assign WrBlk       = r_wr_blk;
    assign ConvEnable  = r_conv_en;
    assign ConvBank    = r_conv_bank;
    assign ConvBlockX  = r_conv_x;
    assign ConvBlockY  = r_conv_y;
    assign ConvComp    = r_conv_comp;
    assign ConvSubW    = r_conv_subw;
    assign ConvSubH    = r_conv_subh;
    assign Busy        = r_busy;
    assign FrameDone   = r_frame_done;
    assign ErrOverflow = r_err;

endmodule

// File: tb/tb_aq_djpeg_mcu_sched.sv
// Directed bench for aq_djpeg_mcu_sched: frame sequencing, bank ping-pong,
// overflow, simultaneous fill/free, ignored restart and mid-frame reset.
module tb_aq_djpeg_mcu_sched;

    logic        clk;
    logic        rst;
    logic        CfgStart;
    logic [11:0] CfgWidthMcu;
    logic [11:0] CfgHeightMcu;
    logic [1:0]  CfgSubW;
    logic [1:0]  CfgSubH;
    logic        BlkValid;
    logic        BlkReady;
    logic        WrBank;
    logic [2:0]  WrBlk;
    logic        ConvEnable;
    logic        ConvBank;
    logic [11:0] ConvBlockX;
    logic [11:0] ConvBlockY;
    logic [2:0]  ConvComp;
    logic [1:0]  ConvSubW;
    logic [1:0]  ConvSubH;
    logic        ConvReadNext;
    logic        Busy;
    logic        FrameDone;
    logic        ErrOverflow;

    int checks = 0;
    int errors = 0;

    aq_djpeg_mcu_sched dut (
        .clk          (clk),
        .rst          (rst),
        .CfgStart     (CfgStart),
        .CfgWidthMcu  (CfgWidthMcu),
        .CfgHeightMcu (CfgHeightMcu),
        .CfgSubW      (CfgSubW),
        .CfgSubH      (CfgSubH),
        .BlkValid     (BlkValid),
        .BlkReady     (BlkReady),
        .WrBank       (WrBank),
        .WrBlk        (WrBlk),
        .ConvEnable   (ConvEnable),
        .ConvBank     (ConvBank),
        .ConvBlockX   (ConvBlockX),
        .ConvBlockY   (ConvBlockY),
        .ConvComp     (ConvComp),
        .ConvSubW     (ConvSubW),
        .ConvSubH     (ConvSubH),
        .ConvReadNext (ConvReadNext),
        .Busy         (Busy),
        .FrameDone    (FrameDone),
        .ErrOverflow  (ErrOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_blk();
        BlkValid = 1'b1;
        tick();
        BlkValid = 1'b0;
    endtask

    task automatic read_next();
        ConvReadNext = 1'b1;
        tick();
        ConvReadNext = 1'b0;
    endtask

    task automatic cfg(input logic [11:0] w, input logic [11:0] h,
                       input logic [1:0] sw, input logic [1:0] sh);
        CfgWidthMcu  = w;
        CfgHeightMcu = h;
        CfgSubW      = sw;
        CfgSubH      = sh;
        CfgStart     = 1'b1;
        tick();
        CfgStart     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; CfgStart = 1'b0; CfgWidthMcu = '0; CfgHeightMcu = '0;
        CfgSubW = '0; CfgSubH = '0; BlkValid = 1'b0; ConvReadNext = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_ready", BlkReady, 0);
        chk("rst_conv_en", ConvEnable, 0);
        chk("rst_wrblk", WrBlk, 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // 1x1 sampling, 2x1 MCUs, converter answers 20 cycles after each issue
        cfg(12'd2, 12'd1, 2'd1, 2'd1);
        chk("s1_busy", Busy, 1);
        chk("s1_ready", BlkReady, 1);
        send_blk(); send_blk(); send_blk();
        chk("s1_wrbank_toggle", WrBank, 1);
        chk("s1_wrblk_wrap", WrBlk, 0);
        chk("s1_en_latency", ConvEnable, 0);
        send_blk();
        chk("s1_en0", ConvEnable, 1);
        chk("s1_bank0", ConvBank, 0);
        chk("s1_x0", ConvBlockX, 0);
        chk("s1_y0", ConvBlockY, 0);
        chk("s1_comp", ConvComp, 3);
        chk("s1_subw", ConvSubW, 1);
        send_blk();
        chk("s1_en_pulse", ConvEnable, 0);
        send_blk();
        chk("s1_stall", BlkReady, 0);
        repeat (17) tick();
        chk("s1_hold_x", ConvBlockX, 0);
        chk("s1_hold_comp", ConvComp, 3);
        read_next();
        chk("s1_no_done", FrameDone, 0);
        chk("s1_convbank1", ConvBank, 1);
        chk("s1_en_gap", ConvEnable, 0);
        tick();
        chk("s1_en1", ConvEnable, 1);
        chk("s1_x1", ConvBlockX, 1);
        chk("s1_y1", ConvBlockY, 0);
        repeat (19) tick();
        read_next();
        chk("s1_done", FrameDone, 1);
        chk("s1_idle", Busy, 0);
        tick();
        chk("s1_done_pulse", FrameDone, 0);

        // 2x2 sampling, single MCU; read-next during ISSUE is ignored
        cfg(12'd1, 12'd1, 2'd2, 2'd2);
        for (int i = 0; i < 6; i++) begin
            chk("s2_wrblk", WrBlk, i);
            send_blk();
        end
        chk("s2_wrblk_wrap", WrBlk, 0);
        chk("s2_en_early", ConvEnable, 0);
        tick();
        chk("s2_en", ConvEnable, 1);
        chk("s2_comp", ConvComp, 6);
        chk("s2_subw", ConvSubW, 2);
        chk("s2_subh", ConvSubH, 2);
        ConvReadNext = 1'b1;
        tick();
        chk("s2_rn_ignored", FrameDone, 0);
        chk("s2_busy", Busy, 1);
        tick();
        ConvReadNext = 1'b0;
        chk("s2_done", FrameDone, 1);
        chk("s2_idle", Busy, 0);

        // 1x1, 3x1 MCUs, converter withheld -> overflow
        cfg(12'd3, 12'd1, 2'd1, 2'd1);
        repeat (6) send_blk();
        chk("s3_ready_off", BlkReady, 0);
        chk("s3_no_err", ErrOverflow, 0);
        send_blk();
        chk("s3_err", ErrOverflow, 1);
        send_blk(); send_blk();
        chk("s3_wrblk", WrBlk, 0);
        chk("s3_wrbank", WrBank, 0);
        read_next();
        chk("s3_ready_back", BlkReady, 1);
        chk("s3_convbank", ConvBank, 1);
        chk("s3_err_sticky", ErrOverflow, 1);
        send_blk();
        chk("s3_en1", ConvEnable, 1);
        chk("s3_x1", ConvBlockX, 1);
        send_blk(); send_blk();
        chk("s3_all_issued", BlkReady, 0);
        read_next();
        chk("s3_convbank0", ConvBank, 0);
        tick();
        chk("s3_en2", ConvEnable, 1);
        chk("s3_x2", ConvBlockX, 2);
        tick();
        read_next();
        chk("s3_done", FrameDone, 1);

        // 2x2 MCUs, fill of bank0 coinciding with release of bank1
        cfg(12'd2, 12'd2, 2'd1, 2'd1);
        chk("s4_err_clr", ErrOverflow, 0);
        send_blk(); send_blk(); send_blk();
        tick();
        chk("s4_en00", ConvEnable, 1);
        chk("s4_x00", ConvBlockX, 0);
        chk("s4_y00", ConvBlockY, 0);
        send_blk(); send_blk(); send_blk();
        chk("s4_wrbank0", WrBank, 0);
        chk("s4_two_ahead", BlkReady, 0);
        read_next();
        chk("s4_convbank1", ConvBank, 1);
        chk("s4_refill", BlkReady, 1);
        send_blk();
        chk("s4_en10", ConvEnable, 1);
        chk("s4_x10", ConvBlockX, 1);
        chk("s4_y10", ConvBlockY, 0);
        send_blk();
        BlkValid = 1'b1;
        ConvReadNext = 1'b1;
        tick();
        BlkValid = 1'b0;
        ConvReadNext = 1'b0;
        chk("s4_sim_wrbank", WrBank, 1);
        chk("s4_sim_convbank", ConvBank, 0);
        chk("s4_sim_ready", BlkReady, 1);
        tick();
        chk("s4_en01", ConvEnable, 1);
        chk("s4_x01", ConvBlockX, 0);
        chk("s4_y01", ConvBlockY, 1);
        send_blk(); send_blk(); send_blk();
        chk("s4_no_done", FrameDone, 0);
        read_next();
        tick();
        chk("s4_en11", ConvEnable, 1);
        chk("s4_x11", ConvBlockX, 1);
        chk("s4_y11", ConvBlockY, 1);
        tick();
        read_next();
        chk("s4_done", FrameDone, 1);
        chk("s4_idle", Busy, 0);

        // restart while busy is ignored; reset mid-frame clears everything
        cfg(12'd2, 12'd1, 2'd1, 2'd1);
        send_blk(); send_blk(); send_blk();
        CfgWidthMcu = 12'd7; CfgSubW = 2'd2; CfgSubH = 2'd2;
        CfgStart = 1'b1;
        tick();
        CfgStart = 1'b0;
        chk("s5_busy", Busy, 1);
        chk("s5_wrbank_kept", WrBank, 1);
        chk("s5_en", ConvEnable, 1);
        chk("s5_comp_kept", ConvComp, 3);
        send_blk();
        chk("s5_wrblk", WrBlk, 1);
        #2 rst = 1'b0;
        #1;
        chk("s5_rst_busy", Busy, 0);
        chk("s5_rst_ready", BlkReady, 0);
        chk("s5_rst_wrbank", WrBank, 0);
        chk("s5_rst_wrblk", WrBlk, 0);
        chk("s5_rst_comp", ConvComp, 0);
        chk("s5_rst_convbank", ConvBank, 0);
        rst = 1'b1;
        tick(); tick(); tick();
        chk("s5_no_done", FrameDone, 0);
        chk("s5_stay_idle", Busy, 0);

        // zero dimensions and an out-of-range sampling code act as 1
        cfg(12'd0, 12'd0, 2'd3, 2'd0);
        send_blk(); send_blk(); send_blk();
        chk("s6_one_mcu", BlkReady, 0);
        tick();
        chk("s6_en", ConvEnable, 1);
        chk("s6_comp", ConvComp, 3);
        chk("s6_subw", ConvSubW, 1);
        tick();
        read_next();
        chk("s6_done", FrameDone, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aq_djpeg_mcu_sched.md
AQ_DJPEG_MCU_SCHED -- requirements
Module: aq_djpeg_mcu_sched

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: CfgStart  in  1  frame start pulse; CfgWidthMcu  in  12  image width in MCUs; CfgHeightMcu  in  12  image height in MCUs; CfgSubW  in  2  horizontal luma sampling; CfgSubH  in  2  vertical luma sampling.
REQ-003 SHALL have ports: BlkValid  in  1  one IDCT 8x8 block written to the write bank; BlkReady  out  1  write bank accepts blocks; WrBank  out  1  bank being filled; WrBlk  out  3  block index within the MCU.
REQ-004 SHALL have ports: ConvEnable  out  1  converter start pulse; ConvBank  out  1  bank being converted; ConvBlockX  out  12  MCU column; ConvBlockY  out  12  MCU row; ConvComp  out  3  blocks per MCU; ConvSubW  out  2  sampling W; ConvSubH  out  2  sampling H; ConvReadNext  in  1  converter finished the MCU.
REQ-005 SHALL have ports: Busy  out  1  frame in progress; FrameDone  out  1  one-cycle end-of-frame pulse; ErrOverflow  out  1  sticky: block dropped.

Function
REQ-006 SHALL derive blocks per MCU BPM = W*H+2, where W = CfgSubW and H = CfgSubH, and any value other than 2 counts as 1: 1x1=3, 2x1=4, 1x2=4, 2x2=6.
REQ-007 SHALL latch config on CfgStart while Busy=0; width or height 0 is treated as 1; CfgStart while Busy=1 is ignored.
REQ-008 SHALL on an accepted CfgStart: set Busy=1; clear both banks to FREE, WrBank, ConvBank, WrBlk, write MCU X/Y and ErrOverflow; set the reader to IDLE.
REQ-009 SHALL keep each bank in state FREE, FILL, FULL or CONV, and SHALL tag each bank with MCU X/Y and a last-MCU flag.
REQ-010 SHALL drive BlkReady = Busy AND (write bank FREE or FILL) AND (write MCUs issued < width*height).
REQ-011 SHALL on BlkValid with BlkReady=1: set the write bank to FILL and increment WrBlk; when WrBlk = BPM-1, set the bank to FULL, capture its X/Y and last flag, reset WrBlk to 0, toggle WrBank, and advance write X (wrapping from width-1 to 0 with Y+1).
REQ-012 SHALL on BlkValid with BlkReady=0: drop the block and set ErrOverflow; ErrOverflow is cleared only by accepted CfgStart or reset.
REQ-013 SHALL use a reader FSM IDLE -> ISSUE -> WAIT -> IDLE. IDLE -> ISSUE when bank[ConvBank] is FULL. ISSUE lasts one cycle, with ConvEnable=1 and the bank set to CONV. WAIT -> IDLE on ConvReadNext, setting the bank FREE and toggling ConvBank.
REQ-014 SHALL assert ConvEnable exactly the cycle after the bank becomes FULL (registered; 1-cycle latency) when the reader is IDLE; the earliest re-issue is the cycle after ConvReadNext.
REQ-015 SHALL hold ConvBlockX/Y, ConvComp (=BPM) and ConvSubW/H stable from ISSUE until ConvReadNext.
REQ-016 SHALL ignore ConvReadNext outside WAIT.
REQ-017 SHALL process simultaneous events independently in one cycle: a bank filling and the other bank freeing both take effect; a bank freed by ConvReadNext may have its FILL begin the next cycle.
REQ-018 SHALL on ConvReadNext for a bank tagged last: pulse FrameDone for one cycle and set Busy=0 in the same cycle.
REQ-019 SHALL never take more than two MCUs ahead of conversion; with both banks FULL/CONV, BlkReady=0.

Reset
REQ-020 SHALL while rst=0 asynchronously force all outputs to 0, both banks to FREE, the reader to IDLE and all counters and config to 0.
REQ-021 SHALL on reset mid-frame abandon the frame entirely; no FrameDone is issued and a new CfgStart is required.

Verification
REQ-022 SHALL cover: cfg 1x1, 2x1 MCUs; send 6 BlkValid, ConvReadNext 20 cycles after each ConvEnable -> ConvEnable with (X,Y)=(0,0), bank0, ConvComp=3; then (1,0), bank1; FrameDone on the second ConvReadNext.
REQ-023 SHALL cover: cfg 2x2, 1x1; send 6 blocks -> WrBlk 0..5, ConvEnable one cycle after the 6th BlkValid, ConvComp=6, ConvSubW=ConvSubH=2.
REQ-024 SHALL cover: cfg 1x1, 3x1; 9 back-to-back blocks, ConvReadNext withheld -> BlkReady=0 after block 6, block 7 drops and sets ErrOverflow=1; releasing the converter restores BlkReady.
REQ-025 SHALL cover: width 2, height 2 -> MCU order (0,0),(1,0),(0,1),(1,1); ConvReadNext on the block-completing cycle of bank0 -> both transitions occur.
REQ-026 SHALL cover: CfgStart while Busy=1 -> ignored; rst low mid-frame -> all outputs 0 and Busy=0 immediately.
